mult_div_unit: RTL and testbench

- Sequential signed multiply/divide engine for the multicycle MIPS datapath. It sits directly downstream of the control FSM.
- The FSM issues Start with DivMult to select the operation, then waits on Done.
- Results go to the HI/LO outputs, which the FSM reads through mfhi/mflo.
- Multiply is radix-2 Booth; divide is restoring division on magnitudes with a final sign fix. Each takes a fixed number of cycles.

---
 rtl/mult_div_unit_pkg.sv | 24 ++
 rtl/mult_div_unit_if.sv | 33 +++
 rtl/mult_div_unit_booth_step.sv | 43 ++++
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared encodings for the sequential multiply/divide engine.
//                Contents:
//                  md_state_t - controller states (IDLE/MULT/DIV/FIX/DONE)
//                  MD_OP_*    - DivMult operation select encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_t;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request/result bundle between the control FSM (master) and
//                the multiply/divide engine (slave).
//                Master drives : Start, DivMult, A, B
//                Slave drives  : Hi, Lo, Busy, Done, DivZero
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             DivMult;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output Start, DivMult, A, B,
        input  Hi, Lo, Busy, Done, DivZero
    );

    modport slave (
        input  Start, DivMult, A, B,
        output Hi, Lo, Busy, Done, DivZero
    );
endinterface : mult_div_unit_if
`default_nettype wire

// File: rtl/mult_div_unit_booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_booth_step
//  Description : One combinational radix-2 Booth iteration on {acc, q, q_1}:
//                add/subtract the multiplicand per {q[0], q_1}, then
//                arithmetic-shift the whole register right by one.
//                Inputs  : i_acc, i_q, i_q1, i_m (multiplicand)
//                Outputs : o_acc, o_q, o_q1 (next register contents)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit_booth_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_acc,
    input  wire logic [WIDTH-1:0] i_q,
    input  wire logic             i_q1,
    input  wire logic [WIDTH-1:0] i_m,
    output logic      [WIDTH-1:0] o_acc,
    output logic      [WIDTH-1:0] o_q,
    output logic                  o_q1
);
    // One guard bit keeps the sign correct when the add/subtract overflows
    // WIDTH bits (e.g. subtracting the most-negative multiplicand); after the
    // shift the result always fits back into WIDTH bits.
    logic [WIDTH:0] w_acc_ext;
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_acc_ext = {i_acc[WIDTH-1], i_acc};
        w_m_ext   = {i_m[WIDTH-1], i_m};
        case ({i_q[0], i_q1})
            2'b01:   w_sum = w_acc_ext + w_m_ext;
            2'b10:   w_sum = w_acc_ext - w_m_ext;
            default: w_sum = w_acc_ext;
        endcase
        o_acc = w_sum[WIDTH:1];
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        o_q1  = i_q[0];
    end

endmodule : mult_div_unit_booth_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Sequential signed multiply/divide engine (MIPS HI/LO).
//                Multiply: radix-2 Booth, WIDTH steps.
//                Divide  : restoring division on magnitudes, WIDTH steps,
//                          followed by one sign-fix cycle.
//                Ports   : Clock, Reset (sync, active-high),
//                          bus (slave: Start/DivMult/A/B in,
//                               Hi/Lo/Busy/Done/DivZero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic       Clock,
    input  wire logic       Reset,
    mult_div_unit_if.slave  bus
);
    md_state_t        state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // Booth accumulator / remainder
    logic [WIDTH-1:0] q_q, q_d;         // multiplier / quotient
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand / |divisor|
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

    logic [WIDTH-1:0] w_booth_acc, w_booth_q;
    logic             w_booth_q1;
    logic [WIDTH:0]   w_div_shift, w_div_trial;
    logic             w_last;

    mult_div_unit_booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .i_acc (acc_q),
        .i_q   (q_q),
        .i_q1  (q1_q),
        .i_m   (m_q),
        .o_acc (w_booth_acc),
        .o_q   (w_booth_q),
        .o_q1  (w_booth_q1)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        w_last = (cnt_q == CNT_W'(WIDTH - 1));

        // Remainder shifted left with the next dividend bit; the extra top
        // bit lets the trial subtraction's sign be read directly.
        w_div_shift = {acc_q, q_q[WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, m_q};

        case (state_q)
            MD_IDLE: begin
                if (bus.Start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    q1_d  = 1'b0;
                    sa_d  = bus.A[WIDTH-1];
                    sb_d  = bus.B[WIDTH-1];
                    dz_d  = 1'b0;
                    if (bus.DivMult == MD_OP_MULT) begin
                        q_d     = bus.B;
                        m_d     = bus.A;
                        state_d = MD_MULT;
                    end else if (bus.B == '0) begin
                        dz_d    = 1'b1;
                        state_d = MD_DONE;
                    end else begin
                        // Magnitudes as unsigned; the most-negative value maps
                        // to itself, which is its correct unsigned magnitude.
                        q_d     = bus.A[WIDTH-1] ? -bus.A : bus.A;
                        m_d     = bus.B[WIDTH-1] ? -bus.B : bus.B;
                        state_d = MD_DIV;
                    end
                end
            end
            MD_MULT: begin
                acc_d = w_booth_acc;
                q_d   = w_booth_q;
                q1_d  = w_booth_q1;
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    hi_d    = w_booth_acc;
                    lo_d    = w_booth_q;
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                if (!w_div_trial[WIDTH]) begin
                    acc_d = w_div_trial[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = w_div_shift[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                // Truncate toward zero: remainder takes the dividend's sign.
                hi_d    = sa_q ? -acc_q : acc_q;
                lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
                state_d = MD_DONE;
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        busy_d    = (state_d == MD_MULT) || (state_d == MD_DIV) || (state_d == MD_FIX);
        done_d    = (state_d == MD_DONE);
        divzero_d = (state_d == MD_DONE) && dz_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= MD_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Expected HI/LO come
//                from plain 64-bit signed arithmetic (product, truncating
//                divide and remainder); timing expectations come from the
//                fixed operation latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int WIDTH = 32;
    localparam int LAT_MULT = WIDTH + 1;
    localparam int LAT_DIV  = WIDTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [WIDTH-1:0] m_hi = '0;
    logic [WIDTH-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check the full Busy/Done timeline and result.
    // glitch_cyc > 0 pulses a stray Start during the busy window;
    // start_in_done pulses Start on the Done cycle.
    task automatic run_op(input logic op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int glitch_cyc,
                          input bit start_in_done);
        longint sa, sb, p, qq, rr;
        logic [WIDTH-1:0] e_hi, e_lo;
        logic e_dz;
        int lat;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1'b0) begin
            p = sa * sb;
            e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 1'b0; lat = LAT_MULT;
        end else if (b == '0) begin
            e_hi = m_hi; e_lo = m_lo; e_dz = 1'b1; lat = 1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            e_hi = rr[31:0]; e_lo = qq[31:0]; e_dz = 1'b0; lat = LAT_DIV;
        end

        @(negedge clk);
        bus.Start = 1'b1; bus.DivMult = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        for (int c = 1; c < lat; c++) begin
            chk("busy_window", {62'd0, bus.Busy, bus.Done}, 64'd2);
            chk("hilo_hold", {bus.Hi, bus.Lo}, {m_hi, m_lo});
            if (c == glitch_cyc) begin
                bus.Start = 1'b1; bus.DivMult = ~op; bus.B = '0;
            end
            @(negedge clk);
            bus.Start = 1'b0;
        end
        chk("done", {63'd0, bus.Done}, 64'd1);
        chk("divzero", {63'd0, bus.DivZero}, {63'd0, e_dz});
        chk("busy_at_done", {63'd0, bus.Busy}, 64'd0);
        chk("hi", {32'd0, bus.Hi}, {32'd0, e_hi});
        chk("lo", {32'd0, bus.Lo}, {32'd0, e_lo});
        m_hi = e_hi;
        m_lo = e_lo;
        if (start_in_done) begin
            bus.Start = 1'b1; bus.DivMult = 1'b0;
        end
        @(negedge clk);
        bus.Start = 1'b0;
        chk("done_pulse", {62'd0, bus.Done, bus.DivZero}, 64'd0);
        chk("idle_busy", {63'd0, bus.Busy}, 64'd0);
        chk("hilo_after", {bus.Hi, bus.Lo}, {m_hi, m_lo});
    endtask

    initial begin
        bus.Start = 1'b0; bus.DivMult = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", {bus.Hi, bus.Lo},  64'd0);
        chk("reset_flags", {61'd0, bus.Busy, bus.Done, bus.DivZero}, 64'd0);
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(1'b1, 32'h0000_0451, 32'h0000_0020, 0, 1'b0);   // Hi=0x11, Lo=0x22
        run_op(1'b1, 32'd5, 32'd0, 0, 1'b0);                   // divide by zero
        run_op(1'b0, 32'd5, 32'd6, 10, 1'b0);                  // stray Start at cycle 10
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 0, 1'b1);         // Start during DONE
        run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_op(1'b1, 32'd3, 32'h8000_0000, 0, 1'b0);

        // Randomized cases
        for (int i = 0; i < 12; i++) begin
            run_op(1'b0, $urandom, $urandom, 0, 1'b0);
            run_op(1'b1, $urandom, $urandom_range(1, 2) == 1 ? $urandom : $urandom_range(0, 40) - 20, 0, 1'b0);
        end

        // Reset in the middle of a multiply at cycle 15
        @(negedge clk);
        bus.Start = 1'b1; bus.DivMult = 1'b0; bus.A = 32'd123; bus.B = 32'd456;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("midrst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("midrst_hilo", {bus.Hi, bus.Lo}, 64'd0);
        chk("midrst_flags", {62'd0, bus.Done, bus.DivZero}, 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("midrst_no_done", {62'd0, bus.Done, bus.Busy}, 64'd0);
        end
        chk("midrst_hilo_end", {bus.Hi, bus.Lo}, 64'd0);

        // Engine still usable after the abort
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
